// File: rtl/clk_rst_mon.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rst_mon
//  Description : Passive checker for the PHY supply/pwrok/reset/clock bring-up
//                sequence, with sticky violation flags and a dfi_clk edge count.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_mon #(
    parameter int MIN_PWROK_TO_RST = 64,
    parameter int MIN_RST_CYC      = 64,
    parameter int MIN_PRESETN_CYC  = 16,
    parameter int WIN_CYC          = 1024,
    parameter int CNT_W            = 16
) (
    input  logic             mon_clk,
    input  logic             reset,
    input  logic             vdd,
    input  logic             vddq,
    input  logic             vaa,
    input  logic             pwrok_in,
    input  logic             presetn,
    input  logic             dfi_reset_n,
    input  logic             phy_reset_in,
    input  logic             dfi_clk,
    input  logic             err_clr,
    output logic [2:0]       seq_state,
    output logic             seq_done,
    output logic [6:0]       err_code,
    output logic             err_any,
    output logic [CNT_W-1:0] dfi_clk_cnt,
    output logic             cnt_valid
);

    // Synchroniser bit positions; vaa sits at bit 0 because it needs no edge flop.
    localparam int c_VAA     = 0;
    localparam int c_VDD     = 1;
    localparam int c_VDDQ    = 2;
    localparam int c_PWROK   = 3;
    localparam int c_PRESETN = 4;
    localparam int c_DFIRSTN = 5;
    localparam int c_PHYRST  = 6;
    localparam int c_DFICLK  = 7;

    localparam logic [7:0] c_SYNC_INIT = 8'b0011_0000;

    localparam logic [2:0] c_ST_OFF    = 3'd0;
    localparam logic [2:0] c_ST_SUPPLY = 3'd1;
    localparam logic [2:0] c_ST_PWROK  = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_WARM   = 3'd4;

    localparam logic [CNT_W-1:0] c_MIN_GAP  = CNT_W'(MIN_PWROK_TO_RST);
    localparam logic [CNT_W-1:0] c_MIN_RST  = CNT_W'(MIN_RST_CYC);
    localparam logic [CNT_W-1:0] c_MIN_PRE  = CNT_W'(MIN_PRESETN_CYC);
    localparam logic [CNT_W-1:0] c_WIN_LAST = CNT_W'(WIN_CYC - 1);

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [7:0]       w_pin;
    logic [7:0]       r_meta;
    logic [7:0]       r_sync;
    logic [7:1]       r_prev;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [6:0]       r_err;
    logic [6:0]       w_err_set;

    assign w_pin = {dfi_clk, phy_reset_in, dfi_reset_n, presetn,
                    pwrok_in, vddq, vdd, vaa};

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_meta <= c_SYNC_INIT;
            r_sync <= c_SYNC_INIT;
            r_prev <= c_SYNC_INIT[7:1];
        end else begin
            r_meta <= w_pin;
            r_sync <= r_meta;
            r_prev <= r_sync[7:1];
        end
    end

    wire w_sup_all      = r_sync[c_VDD] & r_sync[c_VDDQ] & r_sync[c_VAA];
    wire w_pwrok_rise   =  r_sync[c_PWROK]   & ~r_prev[c_PWROK];
    wire w_pwrok_fall   = ~r_sync[c_PWROK]   &  r_prev[c_PWROK];
    wire w_phyrst_rise  =  r_sync[c_PHYRST]  & ~r_prev[c_PHYRST];
    wire w_phyrst_fall  = ~r_sync[c_PHYRST]  &  r_prev[c_PHYRST];
    wire w_presetn_rise =  r_sync[c_PRESETN] & ~r_prev[c_PRESETN];
    wire w_dfirst_rise  =  r_sync[c_DFIRSTN] & ~r_prev[c_DFIRSTN];
    wire w_dficlk_rise  =  r_sync[c_DFICLK]  & ~r_prev[c_DFICLK];
    wire w_supply_fall  = (~r_sync[c_VDD]  & r_prev[c_VDD]) |
                          (~r_sync[c_VDDQ] & r_prev[c_VDDQ]);
    wire w_wrap         = (r_win_cnt == c_WIN_LAST);

    // State register
    always_ff @(posedge mon_clk) begin
        if (reset) r_state <= c_ST_OFF;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; a pwrok drop overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_OFF:    if (w_sup_all)     w_state_nxt = c_ST_SUPPLY;
            c_ST_SUPPLY: if (w_pwrok_rise)  w_state_nxt = c_ST_PWROK;
            c_ST_PWROK:  if (w_phyrst_fall) w_state_nxt = c_ST_RUN;
            c_ST_RUN:    if (w_phyrst_rise) w_state_nxt = c_ST_WARM;
            c_ST_WARM:   if (w_phyrst_fall) w_state_nxt = c_ST_RUN;
            default:                        w_state_nxt = c_ST_OFF;
        endcase
        if (r_state != c_ST_OFF && w_pwrok_fall) w_state_nxt = c_ST_OFF;
    end

    // Output logic
    always_comb begin
        seq_done = (r_state == c_ST_RUN);
    end

    assign seq_state = r_state;
    assign err_code  = r_err;
    assign err_any   = |r_err;

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_gap_cnt <= '0;
            r_rst_cnt <= '0;
            r_pre_cnt <= '0;
        end else begin
            if (r_state == c_ST_SUPPLY && w_state_nxt == c_ST_PWROK) r_gap_cnt <= '0;
            else if (r_state == c_ST_PWROK)                          r_gap_cnt <= f_sat_inc(r_gap_cnt);

            if (r_state == c_ST_RUN && w_state_nxt == c_ST_WARM) r_rst_cnt <= '0;
            else if (r_state == c_ST_WARM)                       r_rst_cnt <= f_sat_inc(r_rst_cnt);

            if (!r_sync[c_PRESETN]) r_pre_cnt <= f_sat_inc(r_pre_cnt);
            else                    r_pre_cnt <= '0;
        end
    end

    // An edge coinciding with the wrap belongs to the new window
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_win_cnt   <= '0;
            r_edge_cnt  <= '0;
            dfi_clk_cnt <= '0;
            cnt_valid   <= 1'b0;
        end else begin
            cnt_valid <= w_wrap;
            if (w_wrap) begin
                r_win_cnt   <= '0;
                dfi_clk_cnt <= r_edge_cnt;
                r_edge_cnt  <= w_dficlk_rise ? CNT_W'(1) : '0;
            end else begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
                if (w_dficlk_rise) r_edge_cnt <= f_sat_inc(r_edge_cnt);
            end
        end
    end

    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = w_pwrok_rise & ~w_sup_all;
        w_err_set[1] = (r_state == c_ST_PWROK) && (w_state_nxt == c_ST_RUN) &&
                       (r_gap_cnt < c_MIN_GAP);
        w_err_set[2] = w_presetn_rise && (r_pre_cnt < c_MIN_PRE);
        w_err_set[3] = w_dfirst_rise & ~r_sync[c_PWROK];
        w_err_set[4] = (r_state == c_ST_WARM) && (w_state_nxt == c_ST_RUN) &&
                       (r_rst_cnt < c_MIN_RST);
        w_err_set[5] = w_supply_fall & r_sync[c_PWROK];
        w_err_set[6] = w_wrap && (r_edge_cnt == '0) &&
                       (r_state == c_ST_RUN || r_state == c_ST_WARM);
    end

    // A new event survives a simultaneous clear
    always_ff @(posedge mon_clk) begin
        if (reset) r_err <= '0;
        else       r_err <= (err_clr ? 7'd0 : r_err) | w_err_set;
    end

endmodule
`default_nettype wire
